mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/wrap_counter8.sv | 20 ++
 rtl/mem_access_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the load/store datapath: address/data/register-index
// widths, the memory access FSM state encoding, and the store-protection test.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int RD_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_e;

  function automatic logic addr_protected(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] lo);
    return (addr >= lo);
  endfunction

endpackage

// File: rtl/wrap_counter8.sv
// Free-running event counter: increments on en, wraps 8'hFF -> 8'h00,
// cleared asynchronously by rst_n.
module wrap_counter8
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [DATA_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between a request port, a data memory and a
// register write-back port. Stores at or above PROTECT_LO are rejected with store_err.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PROTECT_LO = 8'hF0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,

  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,

  output logic              store_err,
  output logic [DATA_W-1:0] load_cnt,
  output logic [DATA_W-1:0] store_cnt
);

  mau_state_e        state_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RD_W-1:0]   rd_q;

  logic              accept;
  logic              req_prot;
  logic              wb_fire;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_prot  = addr_protected(req_addr, PROTECT_LO);
  assign wb_fire   = wb_valid && wb_ready;

  assign read_addr  = addr_q;
  assign write_addr = addr_q;
  assign write_data = wdata_q;

  // Memory strobes are flops set on the accept edge, so the memory sees a clean
  // level for exactly the ACCESS cycle and reset removes them without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      store_err  <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      store_err  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_q       <= req_write;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rd_q       <= req_rd;
            mem_enable <= 1'b1;
            mem_write  <= req_write && !req_prot;
            store_err  <= req_write && req_prot;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wr_q) begin
            state_q <= ST_IDLE;
          end else begin
            wb_data  <= read_data;
            wb_rd    <= rd_q;
            wb_valid <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  wrap_counter8 u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wb_fire),
    .cnt   (load_cnt)
  );

  wrap_counter8 u_store_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_write),
    .cnt   (store_cnt)
  );

endmodule
